// File: rtl/l2_victim_buffer.sv
// Dirty-victim write buffer and pmem arbiter for the L2: victims drain in the background, misses win arbitration.
// Optional L2_VB_FORWARD_EN: serve a miss that hits a buffered victim straight from the buffer.
module l2_victim_buffer #(
  parameter int WAYS     = 8,
  parameter int DEPTH    = 4,
  parameter int LINE_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vb_push_i,
  input  logic [ADDR_W-1:0]         vb_push_addr_i,
  input  logic [LINE_W-1:0]         vb_push_data_i,
  input  logic [$clog2(WAYS)-1:0]   vb_push_way_i,
  output logic                      vb_full_o,
  output logic                      vb_empty_o,
  output logic [$clog2(DEPTH):0]    vb_count_o,
  input  logic                      miss_req_i,
  input  logic [ADDR_W-1:0]         miss_addr_i,
  output logic [LINE_W-1:0]         miss_rdata_o,
  output logic                      miss_resp_o,
  output logic                      pmem_read_o,
  output logic                      pmem_write_o,
  output logic [ADDR_W-1:0]         pmem_address_o,
  output logic [LINE_W-1:0]         pmem_wdata_o,
  input  logic [LINE_W-1:0]         pmem_rdata_i,
  input  logic                      pmem_resp_i,
  output logic [$clog2(WAYS+1)-1:0] pmem_sel_o
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SEL_W = $clog2(WAYS + 1);
  localparam int TAG_W = ADDR_W - OFFSET_W;

`ifdef L2_VB_FORWARD_EN
  typedef enum logic [1:0] {IDLE, MISS_RD, WB_WR, FWD} state_t;
`else
  typedef enum logic [1:0] {IDLE, MISS_RD, WB_WR} state_t;
`endif

  state_t state, nxt;

  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][TAG_W-1:0]  ent_tag;
  logic [DEPTH-1:0][LINE_W-1:0] ent_data;
  logic [DEPTH-1:0][WAY_W-1:0]  ent_way;
  logic [PTR_W-1:0]             head, tail;
  logic [PTR_W:0]               count;

  logic [TAG_W-1:0] push_tag, miss_tag;
  logic [DEPTH-1:0] push_eq, miss_eq;
  logic             miss_hit, miss_go, wb_go, head_busy, push_ok, alloc, co_hit, pop;
  logic [PTR_W-1:0] co_idx;
  logic             unused_offset;

  assign push_tag      = vb_push_addr_i[ADDR_W-1:OFFSET_W];
  assign miss_tag      = miss_addr_i[ADDR_W-1:OFFSET_W];
  assign unused_offset = ^{vb_push_addr_i[OFFSET_W-1:0], miss_addr_i[OFFSET_W-1:0]};

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign push_eq[i] = ent_vld[i] && (ent_tag[i] == push_tag);
    assign miss_eq[i] = ent_vld[i] && (ent_tag[i] == miss_tag);
  end

  assign vb_count_o = count;
  assign vb_full_o  = (count == (PTR_W+1)'(DEPTH));
  assign vb_empty_o = (count == '0);
  assign miss_hit   = |miss_eq;
  // The resp pulse cycle still sees the old request held high; don't re-accept it.
  assign miss_go    = miss_req_i && !miss_resp_o;
  assign wb_go      = (state == IDLE) && (nxt == WB_WR);
  // Head data is captured into pmem_wdata_o on the IDLE decision, so it is frozen from then on.
  assign head_busy  = wb_go || (state == WB_WR);
  assign pop        = (state == WB_WR) && pmem_resp_i;
  assign push_ok    = vb_push_i && !vb_full_o;
  assign alloc      = push_ok && !co_hit;

  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (push_eq[i] && !(head_busy && (PTR_W'(i) == head))) begin
        co_hit = 1'b1;
        co_idx = PTR_W'(i);
      end
  end

`ifdef L2_VB_FORWARD_EN
  logic [PTR_W-1:0] miss_idx, fwd_idx;
  // Walk oldest to newest so the newest matching entry wins.
  always_comb begin
    miss_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (miss_eq[head + PTR_W'(i)]) miss_idx = head + PTR_W'(i);
  end
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (vb_full_o)                nxt = WB_WR;
`ifdef L2_VB_FORWARD_EN
        else if (miss_go && miss_hit) nxt = FWD;
`else
        else if (miss_go && miss_hit) nxt = WB_WR;
`endif
        else if (miss_go)             nxt = MISS_RD;
        else if (!vb_empty_o)         nxt = WB_WR;
      end
      MISS_RD: if (pmem_resp_i) nxt = IDLE;
      WB_WR:   if (pmem_resp_i) nxt = IDLE;
`ifdef L2_VB_FORWARD_EN
      FWD:     nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld        <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      pmem_read_o    <= 1'b0;
      pmem_write_o   <= 1'b0;
      pmem_address_o <= '0;
      pmem_wdata_o   <= '0;
      pmem_sel_o     <= '0;
      miss_rdata_o   <= '0;
      miss_resp_o    <= 1'b0;
`ifdef L2_VB_FORWARD_EN
      fwd_idx        <= '0;
`endif
    end else begin
      miss_resp_o <= 1'b0;
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PTR_W'(1);
        pmem_write_o  <= 1'b0;
        pmem_sel_o    <= '0;
      end
      if (alloc) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      if (alloc && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !alloc) count <= count - (PTR_W+1)'(1);
      if (wb_go) begin
        pmem_write_o   <= 1'b1;
        pmem_address_o <= {ent_tag[head], {OFFSET_W{1'b0}}};
        pmem_wdata_o   <= ent_data[head];
        pmem_sel_o     <= SEL_W'(ent_way[head]) + SEL_W'(1);
      end
      if (state == IDLE && nxt == MISS_RD) begin
        pmem_read_o    <= 1'b1;
        pmem_address_o <= {miss_tag, {OFFSET_W{1'b0}}};
      end
      if (state == MISS_RD && pmem_resp_i) begin
        pmem_read_o  <= 1'b0;
        miss_rdata_o <= pmem_rdata_i;
        miss_resp_o  <= 1'b1;
      end
`ifdef L2_VB_FORWARD_EN
      if (state == IDLE && nxt == FWD) fwd_idx <= miss_idx;
      if (state == FWD) begin
        miss_rdata_o <= ent_data[fwd_idx];
        miss_resp_o  <= 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_tag[tail]  <= push_tag;
      ent_data[tail] <= vb_push_data_i;
      ent_way[tail]  <= vb_push_way_i;
    end else if (push_ok && co_hit) begin
      ent_data[co_idx] <= vb_push_data_i;
      ent_way[co_idx]  <= vb_push_way_i;
    end
  end

  push_when_full: assert property (@(posedge clk) disable iff (rst) !(vb_push_i && vb_full_o));
endmodule

// File: tb/tb_l2_victim_buffer.sv
// Directed bench for l2_victim_buffer: reset, FIFO drain, forwarding/drain-on-hit, coalescing, full arbitration.
module tb_l2_victim_buffer;
  localparam int LW = 256;

  logic          clk = 1'b0, rst = 1'b1;
  logic          vb_push_i = 1'b0;
  logic [31:0]   vb_push_addr_i = '0;
  logic [LW-1:0] vb_push_data_i = '0;
  logic [2:0]    vb_push_way_i = '0;
  logic          vb_full_o, vb_empty_o;
  logic [2:0]    vb_count_o;
  logic          miss_req_i = 1'b0;
  logic [31:0]   miss_addr_i = '0;
  logic [LW-1:0] miss_rdata_o;
  logic          miss_resp_o;
  logic          pmem_read_o, pmem_write_o;
  logic [31:0]   pmem_address_o;
  logic [LW-1:0] pmem_wdata_o;
  logic [LW-1:0] pmem_rdata_i = '0;
  logic          pmem_resp_i = 1'b0;
  logic [3:0]    pmem_sel_o;
  int vectors = 0, errors = 0;

  l2_victim_buffer dut (
    .clk(clk), .rst(rst),
    .vb_push_i(vb_push_i), .vb_push_addr_i(vb_push_addr_i), .vb_push_data_i(vb_push_data_i),
    .vb_push_way_i(vb_push_way_i), .vb_full_o(vb_full_o), .vb_empty_o(vb_empty_o), .vb_count_o(vb_count_o),
    .miss_req_i(miss_req_i), .miss_addr_i(miss_addr_i), .miss_rdata_o(miss_rdata_o), .miss_resp_o(miss_resp_o),
    .pmem_read_o(pmem_read_o), .pmem_write_o(pmem_write_o), .pmem_address_o(pmem_address_o),
    .pmem_wdata_o(pmem_wdata_o), .pmem_rdata_i(pmem_rdata_i), .pmem_resp_i(pmem_resp_i), .pmem_sel_o(pmem_sel_o)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] pat(input logic [31:0] s);
    return {8{s}};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [LW-1:0] d, input logic [2:0] w);
    vb_push_i = 1'b1; vb_push_addr_i = a; vb_push_data_i = d; vb_push_way_i = w;
    step();
    vb_push_i = 1'b0;
  endtask

  task automatic ack(input logic [LW-1:0] d);
    pmem_resp_i = 1'b1; pmem_rdata_i = d;
    step();
    pmem_resp_i = 1'b0;
  endtask

  task automatic wait_pmem(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (pmem_read_o || pmem_write_o) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    step(); step(); rst = 1'b0; step();
    vectors++; if (pmem_read_o !== 1'b0) begin errors++; $display("FAIL reset_read got %b want 0", pmem_read_o); end
    vectors++; if (pmem_write_o !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", pmem_write_o); end
    vectors++; if (miss_resp_o !== 1'b0) begin errors++; $display("FAIL reset_resp got %b want 0", miss_resp_o); end
    vectors++; if (pmem_sel_o !== 4'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", pmem_sel_o); end
    vectors++; if (vb_empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", vb_empty_o); end
    vectors++; if (vb_full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", vb_full_o); end
    vectors++; if (vb_count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", vb_count_o); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    push(32'h700, pat(32'h0000_0700), 3'd0);
    wait_pmem(ok);
    vectors++; if (!ok || pmem_write_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre got write=%b want 1", pmem_write_o); end
    rst = 1'b1;
    step();
    vectors++; if (pmem_write_o !== 1'b0) begin errors++; $display("FAIL rstmid_write got %b want 0", pmem_write_o); end
    vectors++; if (pmem_address_o !== 32'h0) begin errors++; $display("FAIL rstmid_addr got %h want 0", pmem_address_o); end
    vectors++; if (pmem_sel_o !== 4'd0) begin errors++; $display("FAIL rstmid_sel got %0d want 0", pmem_sel_o); end
    vectors++; if (vb_empty_o !== 1'b1 || vb_count_o !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", vb_count_o); end
    rst = 1'b0;
    step(); step(); step();
    vectors++; if (pmem_write_o !== 1'b0 || miss_resp_o !== 1'b0) begin errors++; $display("FAIL rstmid_idle got write=%b resp=%b want 0 0", pmem_write_o, miss_resp_o); end
  endtask

  task automatic test_fifo();
    bit ok;
    logic [31:0] a;
    for (int k = 0; k < 4; k++) push(32'h100 * (k + 1), pat(32'h100 * (k + 1)), 3'(k));
    vectors++; if (vb_full_o !== 1'b1 || vb_count_o !== 3'd4) begin errors++; $display("FAIL fifo_full got full=%b cnt=%0d want 1 4", vb_full_o, vb_count_o); end
    vectors++; if (pmem_write_o !== 1'b1 || pmem_address_o !== 32'h100 || pmem_sel_o !== 4'd1) begin errors++; $display("FAIL fifo_wr0 got a=%h sel=%0d want 100 1", pmem_address_o, pmem_sel_o); end
    ack('0);
    vectors++; if (vb_count_o !== 3'd3 || vb_full_o !== 1'b0) begin errors++; $display("FAIL fifo_pop got cnt=%0d full=%b want 3 0", vb_count_o, vb_full_o); end
    for (int k = 1; k < 4; k++) begin
      a = 32'h100 * (k + 1);
      wait_pmem(ok);
      vectors++; if (!ok || pmem_write_o !== 1'b1 || pmem_read_o !== 1'b0) begin errors++; $display("FAIL fifo_req%0d got wr=%b rd=%b want 1 0", k, pmem_write_o, pmem_read_o); end
      vectors++; if (pmem_address_o !== a || pmem_sel_o !== 4'(k + 1)) begin errors++; $display("FAIL fifo_wr%0d got a=%h sel=%0d want %h %0d", k, pmem_address_o, pmem_sel_o, a, k + 1); end
      vectors++; if (pmem_wdata_o !== pat(a)) begin errors++; $display("FAIL fifo_data%0d got %h want %h", k, pmem_wdata_o, pat(a)); end
      step(); step(); ack('0);
    end
    vectors++; if (vb_empty_o !== 1'b1) begin errors++; $display("FAIL fifo_empty got %b want 1", vb_empty_o); end
  endtask

  task automatic test_forward();
    bit ok;
    push(32'h200, pat(32'hF00D_0200), 3'd5);
    miss_req_i = 1'b1; miss_addr_i = 32'h21C;
`ifdef L2_VB_FORWARD_EN
    step();
    vectors++; if (miss_resp_o !== 1'b0 || pmem_read_o !== 1'b0) begin errors++; $display("FAIL fwd_c1 got resp=%b rd=%b want 0 0", miss_resp_o, pmem_read_o); end
    step();
    vectors++; if (miss_resp_o !== 1'b1 || pmem_read_o !== 1'b0) begin errors++; $display("FAIL fwd_c2 got resp=%b rd=%b want 1 0", miss_resp_o, pmem_read_o); end
    vectors++; if (miss_rdata_o !== pat(32'hF00D_0200)) begin errors++; $display("FAIL fwd_data got %h want %h", miss_rdata_o, pat(32'hF00D_0200)); end
    miss_req_i = 1'b0;
    wait_pmem(ok);
    vectors++; if (!ok || pmem_write_o !== 1'b1 || pmem_address_o !== 32'h200 || pmem_sel_o !== 4'd6) begin errors++; $display("FAIL fwd_wb got a=%h sel=%0d want 200 6", pmem_address_o, pmem_sel_o); end
    step(); step(); ack('0);
`else
    wait_pmem(ok);
    vectors++; if (!ok || pmem_write_o !== 1'b1 || pmem_address_o !== 32'h200 || pmem_sel_o !== 4'd6) begin errors++; $display("FAIL hitwb_wr got a=%h sel=%0d want 200 6", pmem_address_o, pmem_sel_o); end
    step(); step(); ack('0);
    wait_pmem(ok);
    vectors++; if (!ok || pmem_read_o !== 1'b1 || pmem_write_o !== 1'b0 || pmem_address_o !== 32'h200) begin errors++; $display("FAIL hitwb_rd got rd=%b a=%h want 1 200", pmem_read_o, pmem_address_o); end
    vectors++; if (pmem_sel_o !== 4'd0) begin errors++; $display("FAIL hitwb_sel got %0d want 0", pmem_sel_o); end
    step(); ack(pat(32'hD0D0_0200));
    vectors++; if (miss_resp_o !== 1'b1 || miss_rdata_o !== pat(32'hD0D0_0200)) begin errors++; $display("FAIL hitwb_resp got resp=%b data=%h", miss_resp_o, miss_rdata_o); end
    miss_req_i = 1'b0;
`endif
    step();
    vectors++; if (vb_count_o !== 3'd0) begin errors++; $display("FAIL hit_count got %0d want 0", vb_count_o); end
  endtask

  task automatic test_coalesce();
    bit ok;
    miss_req_i = 1'b1; miss_addr_i = 32'h800;
    step();
    push(32'h300, pat(32'hAAAA_0300), 3'd2);
    push(32'h300, pat(32'hBBBB_0300), 3'd3);
    vectors++; if (vb_count_o !== 3'd1) begin errors++; $display("FAIL coal_count got %0d want 1", vb_count_o); end
    vectors++; if (pmem_read_o !== 1'b1 || pmem_write_o !== 1'b0 || pmem_address_o !== 32'h800) begin errors++; $display("FAIL coal_rd got rd=%b a=%h want 1 800", pmem_read_o, pmem_address_o); end
    ack(pat(32'h1234_5678));
    vectors++; if (miss_resp_o !== 1'b1 || miss_rdata_o !== pat(32'h1234_5678)) begin errors++; $display("FAIL coal_resp got resp=%b data=%h", miss_resp_o, miss_rdata_o); end
    miss_req_i = 1'b0;
    wait_pmem(ok);
    vectors++; if (!ok || pmem_write_o !== 1'b1 || pmem_address_o !== 32'h300 || pmem_sel_o !== 4'd4) begin errors++; $display("FAIL coal_wr got a=%h sel=%0d want 300 4", pmem_address_o, pmem_sel_o); end
    vectors++; if (pmem_wdata_o !== pat(32'hBBBB_0300)) begin errors++; $display("FAIL coal_data got %h want %h", pmem_wdata_o, pat(32'hBBBB_0300)); end
    step(); step(); ack('0);
    vectors++; if (vb_count_o !== 3'd0) begin errors++; $display("FAIL coal_empty got %0d want 0", vb_count_o); end
  endtask

  task automatic test_full_miss();
    bit ok;
    logic [31:0] a;
    miss_req_i = 1'b1; miss_addr_i = 32'hA00;
    step();
    for (int k = 0; k < 4; k++) push(32'h100 * (k + 1), pat(32'h100 * (k + 1)), 3'(k));
    vectors++; if (vb_full_o !== 1'b1 || pmem_read_o !== 1'b1) begin errors++; $display("FAIL full_fill got full=%b rd=%b want 1 1", vb_full_o, pmem_read_o); end
    ack(pat(32'hA0A0_A0A0));
    vectors++; if (miss_resp_o !== 1'b1 || miss_rdata_o !== pat(32'hA0A0_A0A0)) begin errors++; $display("FAIL full_resp0 got resp=%b data=%h", miss_resp_o, miss_rdata_o); end
    miss_addr_i = 32'h900;
    step();
    vectors++; if (pmem_write_o !== 1'b1 || pmem_read_o !== 1'b0 || pmem_address_o !== 32'h100 || pmem_sel_o !== 4'd1) begin errors++; $display("FAIL full_wbfirst got wr=%b a=%h sel=%0d want 1 100 1", pmem_write_o, pmem_address_o, pmem_sel_o); end
    step(); ack('0);
    vectors++; if (vb_count_o !== 3'd3 || pmem_write_o !== 1'b0) begin errors++; $display("FAIL full_pop got cnt=%0d wr=%b want 3 0", vb_count_o, pmem_write_o); end
    push(32'h500, pat(32'h500), 3'd4);
    vectors++; if (vb_count_o !== 3'd4) begin errors++; $display("FAIL full_push got cnt=%0d want 4", vb_count_o); end
    vectors++; if (pmem_read_o !== 1'b1 || pmem_write_o !== 1'b0 || pmem_address_o !== 32'h900) begin errors++; $display("FAIL full_rd got rd=%b a=%h want 1 900", pmem_read_o, pmem_address_o); end
    step(); ack(pat(32'h9999_0900));
    vectors++; if (miss_resp_o !== 1'b1 || miss_rdata_o !== pat(32'h9999_0900)) begin errors++; $display("FAIL full_resp1 got resp=%b data=%h", miss_resp_o, miss_rdata_o); end
    miss_req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a = 32'h200 + 32'h100 * k;
      wait_pmem(ok);
      vectors++; if (!ok || pmem_write_o !== 1'b1 || pmem_address_o !== a || pmem_sel_o !== 4'(k + 2)) begin errors++; $display("FAIL full_drain%0d got a=%h sel=%0d want %h %0d", k, pmem_address_o, pmem_sel_o, a, k + 2); end
      vectors++; if (pmem_wdata_o !== pat(a)) begin errors++; $display("FAIL full_data%0d got %h want %h", k, pmem_wdata_o, pat(a)); end
      step(); step(); ack('0);
    end
    vectors++; if (vb_empty_o !== 1'b1) begin errors++; $display("FAIL full_empty got %b want 1", vb_empty_o); end
  endtask

  task automatic test_inflight_dup();
    bit ok;
    push(32'h600, pat(32'h1111_0600), 3'd1);
    push(32'h600, pat(32'h2222_0600), 3'd2);
    vectors++; if (vb_count_o !== 3'd2) begin errors++; $display("FAIL dup_count got %0d want 2", vb_count_o); end
    vectors++; if (pmem_write_o !== 1'b1 || pmem_wdata_o !== pat(32'h1111_0600) || pmem_sel_o !== 4'd2) begin errors++; $display("FAIL dup_wr0 got sel=%0d data=%h", pmem_sel_o, pmem_wdata_o); end
    step(); ack('0);
    vectors++; if (vb_count_o !== 3'd1) begin errors++; $display("FAIL dup_pop got %0d want 1", vb_count_o); end
    wait_pmem(ok);
    vectors++; if (!ok || pmem_address_o !== 32'h600 || pmem_sel_o !== 4'd3 || pmem_wdata_o !== pat(32'h2222_0600)) begin errors++; $display("FAIL dup_wr1 got a=%h sel=%0d data=%h", pmem_address_o, pmem_sel_o, pmem_wdata_o); end
    step(); step(); ack('0);
    vectors++; if (vb_count_o !== 3'd0) begin errors++; $display("FAIL dup_empty got %0d want 0", vb_count_o); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_fifo();
    test_forward();
    test_coalesce();
    test_full_miss();
    test_inflight_dup();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/l2_victim_buffer.md
# l2_victim_buffer

Parametrised dirty-victim write buffer and physical-memory arbiter for the L2 cache, sitting between the L2 control/datapath and the cacheline-level pmem port. Evicted dirty lines are pushed into a DEPTH-entry circular buffer and drained to pmem in the background. CPU miss reads take priority, and a miss that hits a buffered victim is served from the buffer. It generalises the fixed 8-way pmem address select to WAYS ways and replaces stall-on-writeback with buffered write-back.

## Interface
- WAYS, 8: L2 associativity; sets way-tag and select widths.
- DEPTH, 4: victim entries (power of two, ≥2).
- LINE_W, 256: cacheline bits.
- ADDR_W, 32: byte address bits.
- OFFSET_W, 5: line-offset bits, ignored in all address compares.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- vb_push_i  in  1  push victim this cycle.
- vb_push_addr_i  in  ADDR_W  victim line address.
- vb_push_data_i  in  LINE_W  victim line data.
- vb_push_way_i  in  $clog2(WAYS)  way the victim came from.
- vb_full_o  out  1  no free entry; push ignored.
- vb_empty_o  out  1  no valid entry.
- vb_count_o  out  $clog2(DEPTH)+1  valid entries.
- miss_req_i  in  1  L2 miss read; level, held with address until miss_resp_o.
- miss_addr_i  in  ADDR_W  miss line address.
- miss_rdata_o  out  LINE_W  returned line.
- miss_resp_o  out  1  one-cycle completion pulse.
- pmem_read_o  out  1  pmem line read.
- pmem_write_o  out  1  pmem line write.
- pmem_address_o  out  ADDR_W  line-aligned (offset bits zero).
- pmem_wdata_o  out  LINE_W  write data.
- pmem_rdata_i  in  LINE_W  read data, valid with pmem_resp_i.
- pmem_resp_i  in  1  pmem transaction complete.
- pmem_sel_o  out  $clog2(WAYS+1)  0 = cpu miss/idle, k+1 = dirty way k write-back.

## Operation
- Entries: valid, line address, data, way. Circular head/tail pointers with wrap at DEPTH.
- Push when not full:
  - If a valid entry other than an in-flight head has the same line address, overwrite its data and way (coalesce, no count change).
  - Otherwise allocate at tail.
  - Push when full is dropped and flagged by an assertion.
- FSM: IDLE, MISS_RD, FWD, WB_WR.
- IDLE arbitration, in priority order:
  1. count == DEPTH: go to WB_WR, draining the head first so pushes can proceed.
  2. miss_req_i with a buffer match (newest matching entry wins): go to FWD.
  3. miss_req_i without a match: go to MISS_RD.
  4. count > 0: go to WB_WR.
- MISS_RD: pmem_read_o=1, address = miss line. On pmem_resp_i, latch rdata and return to IDLE; miss_resp_o pulses the following cycle.
- FWD: load miss_rdata_o from the entry and pulse miss_resp_o; entry stays valid. Return to IDLE.
- WB_WR: pmem_write_o=1 with head address/data; pmem_sel_o = head.way+1. On pmem_resp_i, pop head and return to IDLE.
- pmem request outputs are registered and stable until pmem_resp_i; read and write are never both high.
- Push and pop in the same cycle: count unchanged; push into the freed slot is allowed only from the next cycle.

## Timing
- Reset: all outputs 0, vb_empty_o=1, all entries invalid, pointers 0, FSM IDLE. Reset mid-transaction abandons it; no miss_resp_o is issued.
- Miss, forwarded: request accepted in IDLE at cycle 0; miss_resp_o at cycle 2.
- Miss, from pmem: pmem_read_o from cycle 1; miss_resp_o one cycle after pmem_resp_i.
- Write-back: pmem_write_o one cycle after IDLE decision. vb_count_o and vb_full_o update the cycle after pmem_resp_i.
- Back-to-back transactions: IDLE always intervenes for at least one cycle.

## Configuration
- L2_VB_FORWARD_EN defined: FWD state and forwarding as above.
- Undefined: no FWD state. A miss matching any entry forces WB_WR drains until no match remains, then MISS_RD. The pmem read therefore always observes the written-back data.

## Test plan
- Reset while pmem_write_o=1 -> next cycle all outputs 0, vb_empty_o=1, vb_count_o=0.
- Push 4 victims, ways 0..3, addresses 0x100,0x200,0x300,0x400, pmem_resp_i after 3 cycles each -> writes in FIFO order; pmem_sel_o=1,2,3,4; vb_full_o high after the 4th push.
- Buffer holds 0x200 (way 5); miss_req_i at 0x21C -> forward build: miss_rdata_o = entry data, miss_resp_o at cycle 2, no pmem_read_o. Non-forward build: write 0x200 with sel 6, then read 0x200.
- Push 0x300 twice with data A then B, no drain -> vb_count_o=1; subsequent write carries B.
- Full buffer plus miss at 0x900 -> head write first, then pmem_read_o at 0x900; a push in the cycle after the pop is accepted.
- Push same address as in-flight head during WB_WR -> new entry allocated; count increments after pop completes net 0.
